// File: rtl/reg_file_sb.sv
// Integer register file with NRD combinational read ports, one write port, optional
// write-to-read bypass, and a per-register busy scoreboard with an incremental count.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec,
  output logic [AW:0]          busy_cnt
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy_q;
  logic [NREGS-1:0]           busy_nxt;
  logic [AW:0]                cnt_q;
  logic [AW:0]                cnt_nxt;
  logic                       iss_nz;
  logic                       inc;
  logic                       dec;

  // A bypassed write hides the stale busy bit because the producer has just arrived.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        if ((BYPASS != 0) && we && (wr_addr == rd_addr[i*AW +: AW])) begin
          rd_data[i*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
          rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  // Issue beats flush beats writeback: the newest producer must stay tracked.
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_valid && (iss_addr == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if (flush) begin
        busy_nxt[r] = 1'b0;
      end else if (we && (wr_addr == AW'(r))) begin
        busy_nxt[r] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  assign iss_nz = iss_valid && (iss_addr != '0);
  assign inc    = iss_nz && !busy_q[iss_addr];
  assign dec    = we && (wr_addr != '0) && busy_q[wr_addr] &&
                  !(iss_valid && (iss_addr == wr_addr));

  always_comb begin
    if (flush) begin
      cnt_nxt = {{AW{1'b0}}, iss_nz};
    end else begin
      cnt_nxt = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs   <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we && (wr_addr != '0)) begin
        regs[wr_addr] <= wr_data;
      end
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: one instance with bypass, one without, shared stimulus.
module tb_reg_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic                we = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       iss_addr = '0;
  logic                flush = 1'b0;
  logic [NREGS-1:0]    busy_vec, busy_vec_nb;
  logic [AW:0]         busy_cnt, busy_cnt_nb;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec), .busy_cnt(busy_cnt));

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_nb), .busy_cnt(busy_cnt_nb));

  typedef struct {
    string           name;
    logic [XLEN-1:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  logic [NREGS-1:0][XLEN-1:0] mregs = '0, mregs_n = '0;
  logic [NREGS-1:0]           mbusy = '0, mbusy_n = '0;

  task automatic apply(input logic iv, input logic [AW-1:0] ia, input logic w,
                       input logic [AW-1:0] wa, input logic [XLEN-1:0] wd, input logic fl);
    iss_valid = iv; iss_addr = ia; we = w; wr_addr = wa; wr_data = wd; flush = fl;
    mregs_n = mregs;
    if (w && wa != '0) mregs_n[wa] = wd;
    mbusy_n = mbusy;
    for (int r = 1; r < NREGS; r++) begin
      if (iv && ia == AW'(r)) mbusy_n[r] = 1'b1;
      else if (fl) mbusy_n[r] = 1'b0;
      else if (w && wa == AW'(r)) mbusy_n[r] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mregs = mregs_n;
    mbusy = mbusy_n;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    sb.push_back('{"rst_busy_vec", '0});
    sb.push_back('{"rst_busy_cnt", '0});
    sb.push_back('{"rst_rd_data0", '0});
    e = sb.pop_front(); checks++;
    if (busy_vec !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, busy_vec, e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
    e = sb.pop_front(); checks++;
    if (rd_data[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data[XLEN-1:0], e.v); end
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_write_read();
    apply(0, 0, 1, 5, 32'hDEADBEEF, 0);
    tick();
    apply(0, 0, 1, 0, 32'h00001234, 0);
    rd_addr = {5'd0, 5'd5};
    sb.push_back('{"x5_read", 32'hDEADBEEF});
    sb.push_back('{"x0_write_same_cycle", '0});
    #1;
    e = sb.pop_front(); checks++;
    if (rd_data[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data[XLEN-1:0], e.v); end
    e = sb.pop_front(); checks++;
    if (rd_data[2*XLEN-1:XLEN] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data[2*XLEN-1:XLEN], e.v); end
    tick();
    apply(0, 0, 0, 0, 0, 0);
    sb.push_back('{"x0_read_after_write", '0});
    #1;
    e = sb.pop_front(); checks++;
    if (rd_data[2*XLEN-1:XLEN] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data[2*XLEN-1:XLEN], e.v); end
    tick();
  endtask

  task automatic test_bypass();
    apply(1, 7, 1, 7, 32'h11111111, 0);
    tick();
    apply(0, 0, 1, 7, 32'hA5A5A5A5, 0);
    rd_addr = {5'd0, 5'd7};
    sb.push_back('{"byp_data", 32'hA5A5A5A5});
    sb.push_back('{"byp_busy", '0});
    sb.push_back('{"nobyp_data_old", 32'h11111111});
    sb.push_back('{"nobyp_busy", 32'd1});
    #1;
    e = sb.pop_front(); checks++;
    if (rd_data[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data[XLEN-1:0], e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(rd_busy[0]) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, rd_busy[0], e.v); end
    e = sb.pop_front(); checks++;
    if (rd_data_nb[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data_nb[XLEN-1:0], e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(rd_busy_nb[0]) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, rd_busy_nb[0], e.v); end
    tick();
    apply(0, 0, 0, 0, 0, 0);
    sb.push_back('{"nobyp_data_next", 32'hA5A5A5A5});
    sb.push_back('{"x7_busy_cleared", '0});
    #1;
    e = sb.pop_front(); checks++;
    if (rd_data_nb[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data_nb[XLEN-1:0], e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_vec[7]) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_vec[7], e.v); end
    tick();
  endtask

  task automatic test_issue();
    apply(1, 3, 0, 0, 0, 0); tick();
    apply(1, 4, 0, 0, 0, 0); tick();
    apply(1, 3, 0, 0, 0, 0);
    sb.push_back('{"iss_busy_vec", 32'h00000018});
    sb.push_back('{"iss_busy_cnt", 32'd2});
    tick();
    e = sb.pop_front(); checks++;
    if (busy_vec !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, busy_vec, e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
    apply(0, 0, 1, 3, 32'h33333333, 0);
    rd_addr = {5'd0, 5'd3};
    sb.push_back('{"wb_busy_cnt", 32'd1});
    sb.push_back('{"wb_rd_busy_x3", '0});
    tick();
    apply(0, 0, 0, 0, 0, 0);
    #1;
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(rd_busy[0]) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, rd_busy[0], e.v); end
    tick();
  endtask

  task automatic test_reissue_with_write();
    apply(1, 9, 0, 0, 0, 0); tick();
    apply(1, 9, 1, 9, 32'h99999999, 0);
    rd_addr = {5'd0, 5'd9};
    sb.push_back('{"x9_still_busy", 32'd1});
    sb.push_back('{"x9_cnt_unchanged", 32'd2});
    sb.push_back('{"x9_data_written", 32'h99999999});
    tick();
    apply(0, 0, 0, 0, 0, 0);
    #1;
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_vec[9]) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_vec[9], e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
    e = sb.pop_front(); checks++;
    if (rd_data[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data[XLEN-1:0], e.v); end
    tick();
  endtask

  task automatic test_flush();
    apply(1, 1, 0, 0, 0, 1); tick();
    apply(1, 2, 0, 0, 0, 0); tick();
    apply(1, 6, 0, 0, 0, 0);
    sb.push_back('{"pre_flush_cnt", 32'd3});
    tick();
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
    apply(1, 8, 0, 0, 0, 1);
    sb.push_back('{"flush_busy_vec", 32'h00000100});
    sb.push_back('{"flush_busy_cnt", 32'd1});
    tick();
    e = sb.pop_front(); checks++;
    if (busy_vec !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, busy_vec, e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
  endtask

  task automatic test_async_reset();
    apply(1, 1, 0, 0, 0, 1); tick();
    apply(1, 2, 0, 0, 0, 0); tick();
    apply(1, 6, 0, 0, 0, 0); tick();
    apply(1, 10, 1, 5, 32'h0BAD0BAD, 0);
    rd_addr = {5'd9, 5'd5};
    sb.push_back('{"pre_rst_cnt", 32'd3});
    sb.push_back('{"pre_rst_x5", 32'hDEADBEEF});
    #1;
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
    e = sb.pop_front(); checks++;
    if (rd_data_nb[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data_nb[XLEN-1:0], e.v); end
    #1 rst = 1'b0;
    sb.push_back('{"arst_busy_vec", '0});
    sb.push_back('{"arst_busy_cnt", '0});
    sb.push_back('{"arst_x9", '0});
    sb.push_back('{"arst_x5_nb", '0});
    #1;
    e = sb.pop_front(); checks++;
    if (busy_vec !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, busy_vec, e.v); end
    e = sb.pop_front(); checks++;
    if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, busy_cnt, e.v); end
    e = sb.pop_front(); checks++;
    if (rd_data[2*XLEN-1:XLEN] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data[2*XLEN-1:XLEN], e.v); end
    e = sb.pop_front(); checks++;
    if (rd_data_nb[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd_data_nb[XLEN-1:0], e.v); end
    @(posedge clk);
    @(negedge clk);
    mregs = '0;
    mbusy = '0;
    sb.push_back('{"held_rst_busy_vec", '0});
    e = sb.pop_front(); checks++;
    if (busy_vec !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, busy_vec, e.v); end
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] ia, wa, ra0, ra1;
    logic [XLEN-1:0] wd, x0, x1;
    logic iv, w, fl, b0;
    for (int n = 0; n < 150; n++) begin
      iv = 1'($urandom_range(0, 1)); ia = AW'($urandom);
      w = 1'($urandom_range(0, 1)); wa = AW'($urandom); wd = $urandom;
      fl = ($urandom_range(0, 15) == 0);
      apply(iv, ia, w, wa, wd, fl);
      ra0 = AW'($urandom);
      ra1 = (n % 4 == 0) ? ra0 : AW'($urandom);
      rd_addr = {ra1, ra0};
      x0 = (ra0 == '0) ? '0 : (w && wa == ra0) ? wd : mregs[ra0];
      x1 = (ra1 == '0) ? '0 : (w && wa == ra1) ? wd : mregs[ra1];
      b0 = (ra0 == '0) ? 1'b0 : (w && wa == ra0) ? 1'b0 : mbusy[ra0];
      sb.push_back('{"rnd_rd0", x0});
      sb.push_back('{"rnd_rd1", x1});
      sb.push_back('{"rnd_busy0", XLEN'(b0)});
      sb.push_back('{"rnd_nb_rd0", (ra0 == '0) ? '0 : mregs[ra0]});
      #1;
      e = sb.pop_front(); checks++;
      if (rd_data[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", e.name, n, rd_data[XLEN-1:0], e.v); end
      e = sb.pop_front(); checks++;
      if (rd_data[2*XLEN-1:XLEN] !== e.v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", e.name, n, rd_data[2*XLEN-1:XLEN], e.v); end
      e = sb.pop_front(); checks++;
      if (XLEN'(rd_busy[0]) !== e.v) begin errors++; $display("FAIL %s[%0d]: got %0d expected %0d", e.name, n, rd_busy[0], e.v); end
      e = sb.pop_front(); checks++;
      if (rd_data_nb[XLEN-1:0] !== e.v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", e.name, n, rd_data_nb[XLEN-1:0], e.v); end
      sb.push_back('{"rnd_busy_vec", mbusy_n});
      sb.push_back('{"rnd_busy_cnt", XLEN'($countones(mbusy_n))});
      tick();
      e = sb.pop_front(); checks++;
      if (busy_vec !== e.v) begin errors++; $display("FAIL %s[%0d]: got %h expected %h", e.name, n, busy_vec, e.v); end
      e = sb.pop_front(); checks++;
      if (XLEN'(busy_cnt) !== e.v) begin errors++; $display("FAIL %s[%0d]: got %0d expected %0d", e.name, n, busy_cnt, e.v); end
      checks++;
      if (busy_cnt_nb !== ($countones(busy_vec_nb)) ) begin errors++; $display("FAIL rnd_nb_popcount[%0d]: got %0d expected %0d", n, busy_cnt_nb, $countones(busy_vec_nb)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_issue();
    test_reissue_with_write();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the RISC-V core: NRD combinational read ports, one write port, and optional write-to-read bypass.
- x0 reads as zero and ignores writes.
- A per-register busy scoreboard tracks pending writebacks and keeps a count of outstanding ones, so a pipelined datapath can detect RAW hazards and stall.
- Sits between decode/issue (read, mark busy) and writeback (write, clear busy).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, minimum 2. AW = $clog2(NREGS).
- NRD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a same-cycle write is visible on read ports and clears the visible busy; 0 = reads return stored state only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- rd_addr  input  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  output  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rd_busy  output  NRD  1 = the register on port i has a pending writeback
- we  input  1  write enable
- wr_addr  input  AW  write address
- wr_data  input  XLEN  write data
- iss_valid  input  1  an instruction issues this cycle with destination iss_addr
- iss_addr  input  AW  destination register of the issuing instruction
- flush  input  1  clear all busy bits (pipeline squash)
- busy_vec  output  NREGS  registered busy bits; bit 0 is always 0
- busy_cnt  output  AW+1  number of set busy bits (registered)

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, busy_vec = 0, busy_cnt = 0. Outputs follow immediately. Release is synchronous to clk.
- Reads are combinational, zero latency:
  - rd_addr=0 -> rd_data=0, rd_busy=0, regardless of writes.
  - BYPASS=1 and we=1 and wr_addr==rd_addr!=0 -> rd_data=wr_data, rd_busy=0.
  - Otherwise rd_data = stored register and rd_busy = busy_vec[rd_addr].
- Writes: on posedge, if we=1 and wr_addr!=0, reg[wr_addr] <= wr_data. A write to x0 is dropped. A write to a non-busy register still updates data.
- Busy next-state, evaluated per register r != 0, in priority order:
  1. iss_valid=1 and iss_addr==r -> 1. Set wins over a same-cycle clear or flush; the new producer supersedes.
  2. flush=1 -> 0.
  3. we=1 and wr_addr==r -> 0.
  4. Otherwise hold.
- iss_valid with iss_addr=0 has no effect.
- busy_cnt is maintained incrementally, not by popcount:
  - flush=1: next = 1 if (iss_valid and iss_addr!=0), else 0.
  - Otherwise next = cnt + inc - dec, where:
    - inc = iss_valid and iss_addr!=0 and busy_vec[iss_addr]==0;
    - dec = we and wr_addr!=0 and busy_vec[wr_addr]==1 and not (iss_valid and iss_addr==wr_addr).
  - Invariant: busy_cnt == popcount(busy_vec) every cycle. Range 0..NREGS-1; the counter never wraps.
- Re-issue to an already-busy register leaves the count unchanged.
- Reset asserted mid-operation clears all state at once, including in-flight issue and write.
- Read ports are independent. Any number of ports may address the same register and all receive identical results.

Test Plan:
- Reset, then write x5=0xDEADBEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF. Write x0=0x1234; rd_addr1=0 -> 0.
- BYPASS=1: we=1, wr_addr=7, wr_data=0xA5A5A5A5 with rd_addr0=7 in the same cycle -> rd_data0=0xA5A5A5A5, rd_busy0=0. BYPASS=0, same stimulus -> old x7 value, new value on the following cycle.
- iss_valid x3, then x4, then x3 again -> busy_vec bits 3,4 set, busy_cnt=2. Write x3 -> busy_cnt=1, rd_busy for x3 = 0.
- Same cycle iss_valid x9 and we x9 with x9 busy -> x9 remains busy, busy_cnt unchanged, data written.
- Busy x1, x2, x6 (busy_cnt=3), then flush together with iss_valid x8 -> busy_vec = bit 8 only, busy_cnt=1.
- Drive rst=0 between clock edges with busy_cnt=3 and registers nonzero -> busy_vec=0, busy_cnt=0 and all reads 0 before the next edge. Random issue/write/flush run checks busy_cnt==popcount(busy_vec) every cycle.
